accum_drain: RTL
================

Name: accum_drain

Overview:
- Output stage directly downstream of the AccumulateQueue in the systolic datapath.
- After a tile finishes accumulating, drains FIFO_LENGTH partial sums from the queue's a_out.
- Requantizes each sum (round, shift, activation, saturate) and streams it out over a valid/ready interface.
- Drives the queue's stall input to apply backpressure.

Parameters:
- A_BITS, 32, width of the signed accumulator word from the queue.
- O_BITS, 8, width of the output word.
- FIFO_LENGTH, 8, words per drain burst; equals the upstream queue depth.
- SHIFT, 8, requantization right-shift amount, 0..A_BITS-1.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- drain_start  in  1  one-cycle pulse; begins a burst; ignored unless IDLE.
- a_in  in  A_BITS  signed sum from the queue's a_out; valid on every DRAIN cycle with stall low.
- stall  out  1  to the queue's stall; high freezes the queue.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  O_BITS  requantized word.
- out_last  out  1  marks the final word of a burst; qualified by out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - state=IDLE, count=0.
  - out_valid=0, out_last=0, out_data=0, stall=0.
  - Synchronous reset wins over all other inputs, including mid-burst: the partial burst is dropped and no out_last is emitted.
- FSM states: IDLE, DRAIN, FLUSH.
  - IDLE -> DRAIN on drain_start.
  - DRAIN -> FLUSH on the cycle the FIFO_LENGTH-th word is captured.
  - FLUSH -> IDLE when that last word is accepted (out_valid && out_ready && out_last).
  - A drain_start pulse in DRAIN or FLUSH is ignored.
- Stall and capture:
  - stall = (state==DRAIN) && out_valid && !out_ready. This is combinational from out_ready; no other path.
  - stall is never asserted in IDLE or FLUSH, so the queue accumulates freely outside bursts.
  - Capture occurs when state==DRAIN and stall==0. The processed a_in is registered into out_data, out_valid=1 next cycle, and count increments.
  - Latency: one cycle from a_in to out_data.
  - With out_ready held high, throughput is one word per cycle and a burst takes FIFO_LENGTH+1 cycles from drain_start to the last word valid.
- Output register:
  - Holds out_data, out_valid and out_last stable while out_valid && !out_ready.
  - Accept and a new capture in the same cycle is legal: the register reloads and out_valid stays 1.
  - Accept with no capture clears out_valid.
- out_last is set with the capture where count==FIFO_LENGTH-1; count then wraps to 0.
- Arithmetic:
  - Sign-extend a_in to A_BITS+1 bits.
  - If SHIFT>0, add 2^(SHIFT-1), then arithmetic right shift by SHIFT (round half up).
  - The rounding add must not overflow: +0x7FFFFFFF rounds correctly.
  - ReLU: negative -> 0.
  - Saturate to unsigned [0, 2^O_BITS-1].

Optional Feature:
- Macro: ACCUM_DRAIN_RELU_EN.
- Defined: ReLU, then unsigned saturation as above.
- Undefined: no ReLU; signed saturation to [-2^(O_BITS-1), 2^(O_BITS-1)-1], two's-complement output.

Decomposition:
- Package accum_pkg holds:
  - the state enum (IDLE, DRAIN, FLUSH);
  - localparam defaults for A_BITS and O_BITS;
  - the count width as $clog2(FIFO_LENGTH+1).
- One sub-module, requant_sat: purely combinational round/shift/activate/saturate, parameterized by A_BITS, O_BITS and SHIFT.
- accum_drain holds the FSM, count and output register.

Test Plan (defaults, out_ready=1 unless stated):
- Rounding: a_in=1000 -> out_data=4; a_in=384 -> 2 (half up); a_in=383 -> 1.
- Saturation: a_in=0x7FFFFFFF -> 255 (RELU_EN) or 127 (without); a_in=-300 -> 0 (RELU_EN) or 0xFF, i.e. -1 (without); a_in=0x80000000 without RELU_EN -> 0x80.
- Full burst: drain_start, a_in=256*k for k=0..7 -> out_data 0..7 on 8 consecutive cycles. out_last only on value 7; busy falls the cycle after acceptance.
- Backpressure: out_ready=0 for 3 cycles mid-burst -> stall=1 those cycles, out_data held, no word lost or duplicated, sequence still 0..7.
- Reset mid-burst: reset after 3 words -> next cycle out_valid=0, stall=0, busy=0. A new drain_start yields a full 8-word burst with out_last on the 8th.
- Ignored start: drain_start pulsed during DRAIN and during FLUSH -> exactly 8 words, single out_last, returns to IDLE.

Source files
------------

// File: rtl/accum_pkg.sv
// =============================================================================
// Module : accum_pkg
// Brief  : Shared defaults, FSM state encoding and count sizing for accum_drain.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

package accum_pkg;

    localparam int A_BITS_DEF      = 32;
    localparam int O_BITS_DEF      = 8;
    localparam int FIFO_LENGTH_DEF = 8;
    localparam int SHIFT_DEF       = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRAIN = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

    function automatic int cnt_width(input int fifo_length);
        return $clog2(fifo_length + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/requant_sat.sv
// =============================================================================
// Module : requant_sat
// Brief  : Combinational round-half-up, arithmetic shift, optional ReLU and
//          saturation of an accumulator word. ReLU/unsigned output is selected
//          by ACCUM_DRAIN_RELU_EN; otherwise the output is signed-saturated.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module requant_sat #(
    parameter int A_BITS = 32,
    parameter int O_BITS = 8,
    parameter int SHIFT  = 8
) (
    input  logic [A_BITS-1:0] a_in,
    output logic [O_BITS-1:0] q_out
);

    // One guard bit keeps the rounding add from overflowing at the positive limit.
    logic signed [A_BITS:0] w_ext;
    logic signed [A_BITS:0] w_rnd;
    logic signed [A_BITS:0] w_shf;

    assign w_ext = $signed({a_in[A_BITS-1], a_in});

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [A_BITS:0] c_half = (A_BITS+1)'(1) << (SHIFT - 1);
            assign w_rnd = w_ext + c_half;
        end else begin : g_no_round
            assign w_rnd = w_ext;
        end
    endgenerate

    assign w_shf = w_rnd >>> SHIFT;

`ifdef ACCUM_DRAIN_RELU_EN
    localparam logic signed [A_BITS:0] c_umax = (A_BITS+1)'((64'd1 << O_BITS) - 64'd1);

    always_comb begin
        q_out = w_shf[O_BITS-1:0];
        if (w_shf[A_BITS]) begin
            q_out = '0;
        end else if (w_shf > c_umax) begin
            q_out = '1;
        end
    end
`else
    localparam logic signed [A_BITS:0] c_smax = (A_BITS+1)'((64'd1 << (O_BITS - 1)) - 64'd1);
    localparam logic signed [A_BITS:0] c_smin = ~c_smax;

    always_comb begin
        q_out = w_shf[O_BITS-1:0];
        if (w_shf > c_smax) begin
            q_out = {1'b0, {(O_BITS-1){1'b1}}};
        end else if (w_shf < c_smin) begin
            q_out = {1'b1, {(O_BITS-1){1'b0}}};
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/accum_drain.sv
// =============================================================================
// Module : accum_drain
// Brief  : Drains FIFO_LENGTH partial sums from the accumulate queue, requantizes
//          them and streams them over valid/ready with queue backpressure.
//          Output activation selected by ACCUM_DRAIN_RELU_EN (see requant_sat).
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module accum_drain
    import accum_pkg::*;
#(
    parameter int A_BITS      = A_BITS_DEF,
    parameter int O_BITS      = O_BITS_DEF,
    parameter int FIFO_LENGTH = FIFO_LENGTH_DEF,
    parameter int SHIFT       = SHIFT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              drain_start,
    input  logic [A_BITS-1:0] a_in,
    output logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [O_BITS-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int            CW         = cnt_width(FIFO_LENGTH);
    localparam logic [CW-1:0] c_last_idx = CW'(FIFO_LENGTH - 1);

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic              r_valid;
    logic              r_last;
    logic [O_BITS-1:0] r_data;
    logic [O_BITS-1:0] w_q;
    logic              w_capture;
    logic              w_accept;
    logic              w_final;

    requant_sat #(
        .A_BITS (A_BITS),
        .O_BITS (O_BITS),
        .SHIFT  (SHIFT)
    ) u_requant (
        .a_in  (a_in),
        .q_out (w_q)
    );

    // Backpressure only while draining, so the queue runs freely between bursts.
    assign stall     = (r_state == ST_DRAIN) && r_valid && !out_ready;
    assign w_capture = (r_state == ST_DRAIN) && !stall;
    assign w_accept  = r_valid && out_ready;
    assign w_final   = (r_count == c_last_idx);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE:  if (drain_start) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_capture && w_final) r_state <= ST_FLUSH;
                ST_FLUSH: if (w_accept && r_last) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase

            if (w_capture) begin
                r_data  <= w_q;
                r_valid <= 1'b1;
                r_last  <= w_final;
                r_count <= w_final ? '0 : r_count + 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_last  = r_last;
    assign out_data  = r_data;
    assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire
